// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage directly upstream of the ALU.
// Decodes one MIPS instruction per cycle into ALUOp, shamt, operands and
// destination, registers them on the rising edge of clock, and handles
// stall/flush, single-entry EX forwarding and illegal-instruction counting.
module alu_issue #(
    parameter int FORWARD_EN = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      instr,
    input  logic             in_valid,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      ex_result,
    output logic [31:0]      rs,
    output logic [31:0]      rt,
    output logic [3:0]       ALUOp,
    output logic [4:0]       shamt,
    output logic [4:0]       dest,
    output logic             regwrite,
    output logic             out_valid,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [3:0] {
        ALU_NOP = 4'b0000,
        ALU_ADD = 4'b0001,
        ALU_SUB = 4'b0010,
        ALU_AND = 4'b0011,
        ALU_OR  = 4'b0100,
        ALU_NOR = 4'b0101,
        ALU_SLT = 4'b0110,
        ALU_SLL = 4'b0111,
        ALU_SRL = 4'b1000,
        ALU_SRA = 4'b1001
    } alu_op_e;

    logic [31:0]      rs_q, rs_d;
    logic [31:0]      rt_q, rt_d;
    alu_op_e          aluop_q, aluop_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [4:0]       dest_q, dest_d;
    logic             regwrite_q, regwrite_d;
    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        dec_legal;
    logic        dec_is_r;
    logic        dec_sext;
    alu_op_e     dec_op;
    logic [31:0] imm_ext;
    logic        fwd_rs;
    logic        fwd_rt;
    logic        load_en;
    logic [4:0]  load_dest;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // Decode opcode/funct into the ALU function and immediate extension kind
    always_comb begin
        dec_legal = 1'b1;
        dec_is_r  = (opcode == 6'h00);
        dec_sext  = 1'b0;
        dec_op    = ALU_NOP;
        if (dec_is_r) begin
            case (funct)
                6'h20:   dec_op = ALU_ADD;
                6'h22:   dec_op = ALU_SUB;
                6'h24:   dec_op = ALU_AND;
                6'h25:   dec_op = ALU_OR;
                6'h27:   dec_op = ALU_NOR;
                6'h2A:   dec_op = ALU_SLT;
                6'h00:   dec_op = ALU_SLL;
                6'h02:   dec_op = ALU_SRL;
                6'h03:   dec_op = ALU_SRA;
                default: dec_legal = 1'b0;
            endcase
        end else begin
            case (opcode)
                6'h08: begin dec_op = ALU_ADD; dec_sext = 1'b1; end
                6'h0A: begin dec_op = ALU_SLT; dec_sext = 1'b1; end
                6'h0C:   dec_op = ALU_AND;
                6'h0D:   dec_op = ALU_OR;
                default: dec_legal = 1'b0;
            endcase
        end
    end

    assign imm_ext   = dec_sext ? {{16{instr[15]}}, instr[15:0]} : {16'h0000, instr[15:0]};
    assign load_dest = dec_is_r ? instr[15:11] : instr[20:16];
    assign load_en   = !flush && !stall;

    // Forwarding compares against the instruction currently held on the outputs
    assign fwd_rs = (FORWARD_EN != 0) && out_valid_q && regwrite_q && (dest_q == instr[25:21]);
    assign fwd_rt = (FORWARD_EN != 0) && out_valid_q && regwrite_q && (dest_q == instr[20:16]);

    // Next-state: flush beats stall beats load; empty or illegal loads become bubbles
    always_comb begin
        rs_d        = rs_q;
        rt_d        = rt_q;
        aluop_d     = aluop_q;
        shamt_d     = shamt_q;
        dest_d      = dest_q;
        regwrite_d  = regwrite_q;
        out_valid_d = out_valid_q;
        illegal_d   = 1'b0;
        count_d     = count_q;

        if (flush || (load_en && !(in_valid && dec_legal))) begin
            rs_d        = '0;
            rt_d        = '0;
            aluop_d     = ALU_NOP;
            shamt_d     = '0;
            dest_d      = '0;
            regwrite_d  = 1'b0;
            out_valid_d = 1'b0;
        end

        if (load_en && in_valid && !dec_legal) begin
            illegal_d = 1'b1;
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end

        if (load_en && in_valid && dec_legal) begin
            rs_d        = fwd_rs ? ex_result : rs_data;
            rt_d        = !dec_is_r ? imm_ext : (fwd_rt ? ex_result : rt_data);
            aluop_d     = dec_op;
            shamt_d     = dec_is_r ? instr[10:6] : 5'd0;
            dest_d      = load_dest;
            regwrite_d  = (load_dest != 5'd0);
            out_valid_d = 1'b1;
        end
    end

    // Issue register, cleared asynchronously
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rs_q        <= '0;
            rt_q        <= '0;
            aluop_q     <= ALU_NOP;
            shamt_q     <= '0;
            dest_q      <= '0;
            regwrite_q  <= 1'b0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            aluop_q     <= aluop_d;
            shamt_q     <= shamt_d;
            dest_q      <= dest_d;
            regwrite_q  <= regwrite_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            count_q     <= count_d;
        end
    end

    assign rs            = rs_q;
    assign rt            = rt_q;
    assign ALUOp         = aluop_q;
    assign shamt         = shamt_q;
    assign dest          = dest_q;
    assign regwrite      = regwrite_q;
    assign out_valid     = out_valid_q;
    assign illegal       = illegal_q;
    assign illegal_count = count_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: two alu_issue instances (forwarding on / 8-bit counter, and
// forwarding off / 2-bit counter) driven with the same stimulus and compared
// every cycle against an instruction-level reference model.
module tb_alu_issue;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr = '0;
    logic        in_valid = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] ex_result = '0;

    logic [31:0] rs_o [2];
    logic [31:0] rt_o [2];
    logic [3:0]  op_o [2];
    logic [4:0]  sh_o [2];
    logic [4:0]  dst_o [2];
    logic        rw_o [2];
    logic        v_o [2];
    logic        ill_o [2];
    logic [7:0]  cnt0;
    logic [1:0]  cnt1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    alu_issue #(.FORWARD_EN(1), .CNT_W(8)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .instr(instr), .in_valid(in_valid),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
        .ex_result(ex_result), .rs(rs_o[0]), .rt(rt_o[0]), .ALUOp(op_o[0]),
        .shamt(sh_o[0]), .dest(dst_o[0]), .regwrite(rw_o[0]), .out_valid(v_o[0]),
        .illegal(ill_o[0]), .illegal_count(cnt0)
    );

    alu_issue #(.FORWARD_EN(0), .CNT_W(2)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .instr(instr), .in_valid(in_valid),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
        .ex_result(ex_result), .rs(rs_o[1]), .rt(rt_o[1]), .ALUOp(op_o[1]),
        .shamt(sh_o[1]), .dest(dst_o[1]), .regwrite(rw_o[1]), .out_valid(v_o[1]),
        .illegal(ill_o[1]), .illegal_count(cnt1)
    );

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  op;
        logic [4:0]  sh;
        logic [4:0]  dst;
        logic        rw;
        logic        v;
        logic        ill;
        int          cnt;
    } st_t;

    st_t m [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic st_t bubble(input int cnt);
        st_t n;
        n.rs = 0; n.rt = 0; n.op = 0; n.sh = 0; n.dst = 0;
        n.rw = 0; n.v = 0; n.ill = 0; n.cnt = cnt;
        return n;
    endfunction

    // Reference: what the issue stage holds after one edge, from instruction semantics
    function automatic st_t step(input st_t cur, input bit fwd_en, input int cmax,
                                 input logic [31:0] ins, input logic iv,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic stl, input logic fl, input logic [31:0] ex);
        st_t n;
        int code;
        bit is_r;
        bit sext;
        logic signed [15:0] imm;
        code = -1;
        sext = 0;
        is_r = (ins[31:26] == 6'h00);
        imm  = ins[15:0];
        if (fl) return bubble(cur.cnt);
        if (stl) begin
            n = cur;
            n.ill = 0;
            return n;
        end
        if (!iv) return bubble(cur.cnt);
        if (is_r) begin
            case (ins[5:0])
                6'h20: code = 1;
                6'h22: code = 2;
                6'h24: code = 3;
                6'h25: code = 4;
                6'h27: code = 5;
                6'h2A: code = 6;
                6'h00: code = 7;
                6'h02: code = 8;
                6'h03: code = 9;
                default: code = -1;
            endcase
        end else begin
            case (ins[31:26])
                6'h08: begin code = 1; sext = 1; end
                6'h0A: begin code = 6; sext = 1; end
                6'h0C: code = 3;
                6'h0D: code = 4;
                default: code = -1;
            endcase
        end
        if (code < 0) begin
            n = bubble((cur.cnt < cmax) ? cur.cnt + 1 : cur.cnt);
            n.ill = 1;
            return n;
        end
        n.v   = 1;
        n.ill = 0;
        n.cnt = cur.cnt;
        n.op  = code[3:0];
        n.rs  = (fwd_en && cur.v && cur.rw && cur.dst == ins[25:21]) ? ex : a;
        if (is_r) begin
            n.rt  = (fwd_en && cur.v && cur.rw && cur.dst == ins[20:16]) ? ex : b;
            n.dst = ins[15:11];
            n.sh  = ins[10:6];
        end else begin
            n.rt  = sext ? 32'(imm) : 32'(ins[15:0]);
            n.dst = ins[20:16];
            n.sh  = 0;
        end
        n.rw = (n.dst != 0);
        return n;
    endfunction

    task automatic check_all(input string ph);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.d%0d.rs", ph, i), rs_o[i], m[i].rs);
            check($sformatf("%s.d%0d.rt", ph, i), rt_o[i], m[i].rt);
            check($sformatf("%s.d%0d.aluop", ph, i), 32'(op_o[i]), 32'(m[i].op));
            check($sformatf("%s.d%0d.shamt", ph, i), 32'(sh_o[i]), 32'(m[i].sh));
            check($sformatf("%s.d%0d.dest", ph, i), 32'(dst_o[i]), 32'(m[i].dst));
            check($sformatf("%s.d%0d.regwrite", ph, i), 32'(rw_o[i]), 32'(m[i].rw));
            check($sformatf("%s.d%0d.out_valid", ph, i), 32'(v_o[i]), 32'(m[i].v));
            check($sformatf("%s.d%0d.illegal", ph, i), 32'(ill_o[i]), 32'(m[i].ill));
            check($sformatf("%s.d%0d.count", ph, i), (i == 0) ? 32'(cnt0) : 32'(cnt1), m[i].cnt);
        end
    endtask

    // Drive one cycle's inputs, advance the model, sample 1 time unit after the edge
    task automatic cycle(input logic [31:0] ins, input logic iv, input logic [31:0] a,
                         input logic [31:0] b, input logic stl, input logic fl,
                         input logic [31:0] ex, input string ph);
        instr = ins; in_valid = iv; rs_data = a; rt_data = b;
        stall = stl; flush = fl; ex_result = ex;
        m[0] = step(m[0], 1, 255, ins, iv, a, b, stl, fl, ex);
        m[1] = step(m[1], 0, 3, ins, iv, a, b, stl, fl, ex);
        @(posedge clock);
        #1;
        check_all(ph);
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        logic [5:0] opc;
        logic [5:0] fn;
        logic [31:0] ins;
        k   = $urandom_range(0, 9);
        opc = 6'h00;
        fn  = 6'h20;
        if (k <= 4) begin
            case ($urandom_range(0, 8))
                0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
                3: fn = 6'h25; 4: fn = 6'h27; 5: fn = 6'h2A;
                6: fn = 6'h00; 7: fn = 6'h02; default: fn = 6'h03;
            endcase
        end else if (k <= 7) begin
            case ($urandom_range(0, 3))
                0: opc = 6'h08; 1: opc = 6'h0A; 2: opc = 6'h0C; default: opc = 6'h0D;
            endcase
        end else if (k == 8) begin
            case ($urandom_range(0, 3))
                0: fn = 6'h01; 1: fn = 6'h21; 2: fn = 6'h26; default: fn = 6'h08;
            endcase
        end else begin
            case ($urandom_range(0, 3))
                0: opc = 6'h02; 1: opc = 6'h23; 2: opc = 6'h2B; default: opc = 6'h3F;
            endcase
        end
        ins = {opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
        if (opc == 6'h00) begin
            ins[15:11] = 5'($urandom_range(0, 3));
            ins[10:6]  = 5'($urandom);
            ins[5:0]   = fn;
        end
        return ins;
    endfunction

    initial begin
        m[0] = bubble(0);
        m[1] = bubble(0);
        repeat (2) @(posedge clock);
        #1;
        check_all("rst");
        reset_n = 1'b1;
        cycle(32'h0, 0, 0, 0, 0, 0, 0, "idle");

        cycle(32'h00221820, 1, 5, 7, 0, 0, 0, "add");
        check("add.op", 32'(op_o[0]), 32'd1);
        check("add.dest", 32'(dst_o[0]), 32'd3);
        cycle(32'h00612022, 1, 0, 5, 0, 0, 12, "sub");
        check("fwd.rs", rs_o[0], 32'd12);
        check("nofwd.rs", rs_o[1], 32'd0);
        cycle(32'h2005FFFC, 1, 0, 0, 0, 0, 1, "addi");
        check("addi.rt", rt_o[0], 32'hFFFFFFFC);
        cycle(32'h34068000, 1, 0, 0, 0, 0, 2, "ori");
        check("ori.rt", rt_o[0], 32'h00008000);
        cycle(32'h00011100, 1, 0, 3, 0, 0, 3, "sll");
        check("sll.shamt", 32'(sh_o[0]), 32'd4);

        for (int i = 0; i < 3; i++) cycle(rand_instr(), 1, $urandom, $urandom, 1, 0, $urandom, "stall");
        check("stall.rt", rt_o[0], 32'd3);
        cycle(32'h00221820, 1, 9, 9, 1, 1, 0, "stflush");
        check("stflush.valid", 32'(v_o[0]), 32'd0);
        cycle(32'h00221820, 1, 5, 7, 0, 0, 0, "release");

        cycle(32'hFC000000, 1, 0, 0, 0, 0, 0, "ill");
        check("ill.pulse", 32'(ill_o[0]), 32'd1);
        check("ill.count", 32'(cnt0), 32'd1);
        cycle(32'h00221820, 1, 5, 7, 0, 0, 0, "illafter");
        cycle(32'hFC000000, 1, 0, 0, 1, 0, 0, "illstall");
        check("illstall.count", 32'(cnt0), 32'd1);
        for (int i = 0; i < 5; i++) cycle(32'hFC000000, 1, 0, 0, 0, 0, 0, "ill5");
        check("sat.count", 32'(cnt1), 32'd3);
        check("ill6.count", 32'(cnt0), 32'd6);

        for (int i = 0; i < 200; i++) begin
            cycle(rand_instr(), ($urandom_range(0, 9) != 0), $urandom, $urandom,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), $urandom, "rnd");
        end

        #2;
        reset_n = 1'b0;
        m[0] = bubble(0);
        m[1] = bubble(0);
        #1;
        check_all("amid");
        instr = 32'h00221820; in_valid = 1'b1;
        @(posedge clock);
        #1;
        check_all("rsthold");
        reset_n = 1'b1;
        cycle(32'h0, 0, 0, 0, 0, 0, 0, "postrst");

        for (int i = 0; i < 400; i++) begin
            cycle(rand_instr(), ($urandom_range(0, 9) != 0), $urandom, $urandom,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), $urandom, "rnd2");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode/issue stage directly upstream of the ALU. Accepts one MIPS instruction word plus its register-file read data per cycle. Decodes it to the ALU's 4-bit ALUOp, shamt and operands, and registers them on the rising edge of `clock`, so the ALU can sample stable values on the following falling edge. Provides stall and flush control, a single-entry EX→issue forwarding path, and illegal-instruction detection and counting.

## Interface
- FORWARD_EN, 1, 1 enables forwarding of `ex_result`; 0 always uses register-file data
- CNT_W, 8, width of the saturating illegal-instruction counter
- clock  in  1  sole clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- instr  in  32  instruction word
- in_valid  in  1  instr, rs_data and rt_data are valid this cycle
- rs_data  in  32  register-file value of instr[25:21]
- rt_data  in  32  register-file value of instr[20:16]
- stall  in  1  hold all outputs and accept nothing
- flush  in  1  replace the issued instruction with a bubble
- ex_result  in  32  ALU result of the instruction currently issued (fed back)
- rs  out  32  ALU operand A
- rt  out  32  ALU operand B (register or extended immediate)
- ALUOp  out  4  ALU function code
- shamt  out  5  shift amount
- dest  out  5  destination register
- regwrite  out  1  issued instruction writes dest
- out_valid  out  1  outputs hold a real instruction
- illegal  out  1  one-cycle pulse: undecodable instruction dropped
- illegal_count  out  CNT_W  saturating count of illegal instructions

## Operation
- R-type (op 0x00), funct → ALUOp:
  - 0x20 add 0001, 0x22 sub 0010, 0x24 and 0011, 0x25 or 0100, 0x27 nor 0101
  - 0x2A slt 0110, 0x00 sll 0111, 0x02 srl 1000, 0x03 sra 1001
  - dest = instr[15:11]; shamt = instr[10:6]; rt = register value
- I-type, dest = instr[20:16], shamt = 0:
  - 0x08 addi 0001, rt = sign-extended imm
  - 0x0A slti 0110, rt = sign-extended imm
  - 0x0C andi 0011, rt = zero-extended imm
  - 0x0D ori 0100, rt = zero-extended imm
- Any other opcode/funct is illegal: issue a bubble, pulse `illegal`, increment `illegal_count`. The count saturates at 2^CNT_W−1 and is never cleared except by reset.
- regwrite = 1 for every legal instruction except dest = 0.
- Bubble: out_valid = 0, regwrite = 0, ALUOp = 0000, rs = rt = 0, shamt = 0, dest = 0. The ALU therefore computes 0.
- Forwarding (FORWARD_EN = 1), evaluated against the currently registered outputs:
  - If out_valid & regwrite & dest == instr[25:21], rs takes ex_result.
  - Same rule for R-type rt against instr[20:16].
  - The immediate operand is never forwarded.
- Priority each posedge: flush > stall > load. `flush` beats `stall`.
  - Load with in_valid = 0 issues a bubble.
- Stall: nothing accepted, no illegal detection or counting, outputs unchanged.

## Timing
- Latency: instr presented before posedge N appears on the outputs after posedge N. The ALU consumes it at the negedge in cycle N.
- ex_result for the issued instruction is valid before the next posedge and is used for forwarding at that edge.
- `illegal` is high exactly one cycle, aligned with the bubble it produces.
- Reset (asynchronous, mid-operation included): all outputs 0, illegal_count 0, ALUOp 0000, at once and independent of clock. The first load is at the first posedge after reset_n rises.
- Throughput: one instruction per cycle when stall = 0.

## Test plan
- Reset: assert reset_n = 0 mid-stream between edges → all outputs read 0 immediately; they stay 0 until the first posedge with in_valid = 1 after release.
- Basic R-type: instr 0x00221820 (add $3,$1,$2), rs_data 5, rt_data 7 → ALUOp 0001, rs 5, rt 7, dest 3, regwrite 1, out_valid 1.
- Forwarding: next cycle instr 0x00612022 (sub $4,$3,$1), rs_data 0 (stale), rt_data 5, ex_result 12 → rs 12, rt 5, ALUOp 0010, dest 4. With FORWARD_EN = 0 → rs 0.
- Immediates and shifts (three cycles):
  - 0x2005FFFC → rt 0xFFFFFFFC, ALUOp 0001, dest 5
  - 0x34068000 → rt 0x00008000, ALUOp 0100, dest 6
  - 0x00011100 with rt_data 3 → ALUOp 0111, shamt 4, rt 3, dest 2
- Stall/flush: stall held 3 cycles with changing instr → outputs constant. Stall and flush together → bubble. Stall release → next instr issued.
- Illegal: instr 0xFC000000 → bubble, illegal pulse 1 cycle, count 1. Presented while stalled → no pulse, no count. With CNT_W = 2, five illegals → count 3.
